piso_transmitter: RTL and testbench

PISO_TRANSMITTER -- requirements
Module: piso_transmitter

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_bit_timer.sv | 32 +++
 rtl/piso_transmitter.sv | 122 ++++++++++++
 tb/tb_piso_transmitter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame bit levels,
// data width and the default oversampling ratio.
package uart_pkg;

    // Transmitter states. PARITY is only entered when PARITY_BIT_EN is defined.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic START_BIT            = 1'b0;
    localparam logic STOP_BIT             = 1'b1;
    localparam int   DATA_BITS            = 8;
    localparam int   DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and wraps to 0,
// flagging the last cycle of each bit period on bit_end.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic baud_clock,
    input  logic reset_active_high,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_reg;

    // bit_end is combinational so the FSM can change bit on the same edge the count wraps
    assign bit_end = enable && (count_reg == LAST_COUNT);

    // Count within a bit period; clear restarts timing at frame acceptance
    always_ff @(posedge baud_clock) begin
        if (reset_active_high || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= bit_end ? '0 : count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/piso_transmitter.sv
// Parallel-in serial-out UART transmitter: start bit, 8 data bits LSB first,
// optional parity bit, stop bit, each held CLKS_PER_BIT baud_clock cycles.
// Optional feature: define PARITY_BIT_EN to insert the parity bit (11-bit frame);
// otherwise the frame is 10 bits and PARITY_ODD has no effect.
module piso_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY_ODD   = 0
) (
    input  logic       baud_clock,
    input  logic       reset_active_high,
    input  logic [7:0] parallel_data_in,
    input  logic       send_request,
    output logic       serial_data_out,
    output logic       is_active,
    output logic       tx_done
);

    localparam logic [2:0] LAST_DATA_BIT = 3'(DATA_BITS - 1);

    tx_state_t  state_reg;
    logic [7:0] shift_reg;
    logic [2:0] bit_cnt_reg;
    logic       accept;
    logic       bit_end;

`ifdef PARITY_BIT_EN
    logic parity_reg;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
`endif

    assign accept    = (state_reg == ST_IDLE) && send_request;
    assign is_active = (state_reg != ST_IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .baud_clock        (baud_clock),
        .reset_active_high (reset_active_high),
        .clear             (accept),
        .enable            (is_active),
        .bit_end           (bit_end)
    );

    // Frame sequencer; the line level for the next bit is registered on the
    // same edge that enters that bit, so serial_data_out never glitches.
    always_ff @(posedge baud_clock) begin
        if (reset_active_high) begin
            state_reg       <= ST_IDLE;
            serial_data_out <= STOP_BIT;
            tx_done         <= 1'b0;
            shift_reg       <= '0;
            bit_cnt_reg     <= '0;
`ifdef PARITY_BIT_EN
            parity_reg      <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    serial_data_out <= STOP_BIT;
                    if (send_request) begin
                        shift_reg       <= parallel_data_in;
                        bit_cnt_reg     <= '0;
                        state_reg       <= ST_START;
                        serial_data_out <= START_BIT;
`ifdef PARITY_BIT_EN
                        // Parity is taken from the byte as latched, before shifting
                        parity_reg      <= (^parallel_data_in) ^ (PARITY_ODD != 0);
`endif
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state_reg       <= ST_DATA;
                        serial_data_out <= shift_reg[0];
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift_reg   <= shift_reg >> 1;
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == LAST_DATA_BIT) begin
`ifdef PARITY_BIT_EN
                            state_reg       <= ST_PARITY;
                            serial_data_out <= parity_reg;
`else
                            state_reg       <= ST_STOP;
                            serial_data_out <= STOP_BIT;
`endif
                        end else begin
                            serial_data_out <= shift_reg[1];
                        end
                    end
                end
`ifdef PARITY_BIT_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        state_reg       <= ST_STOP;
                        serial_data_out <= STOP_BIT;
                    end
                end
`endif
                ST_STOP: begin
                    serial_data_out <= STOP_BIT;
                    if (bit_end) begin
                        state_reg <= ST_IDLE;
                        tx_done   <= 1'b1;
                    end
                end
                default: begin
                    state_reg       <= ST_IDLE;
                    serial_data_out <= STOP_BIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_transmitter.sv
// Self-checking bench for piso_transmitter. Two instances (even and odd parity)
// share one stimulus stream; every cycle of every frame is compared with a
// frame built from the byte, and the line is also decoded at bit centres.
module tb_piso_transmitter;

    localparam int CPB = 16;
`ifdef PARITY_BIT_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYCLES = FRAME_BITS * CPB;

    logic       baud_clock        = 1'b0;
    logic       reset_active_high = 1'b1;
    logic       send_request      = 1'b0;
    logic [7:0] parallel_data_in  = 8'h00;
    logic [1:0] line;
    logic [1:0] active;
    logic [1:0] done;

    int vectors     = 0;
    int miscompares = 0;

    always #5 baud_clock = ~baud_clock;

    piso_transmitter #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut_even (
        .baud_clock        (baud_clock),
        .reset_active_high (reset_active_high),
        .parallel_data_in  (parallel_data_in),
        .send_request      (send_request),
        .serial_data_out   (line[0]),
        .is_active         (active[0]),
        .tx_done           (done[0])
    );

    piso_transmitter #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1)) dut_odd (
        .baud_clock        (baud_clock),
        .reset_active_high (reset_active_high),
        .parallel_data_in  (parallel_data_in),
        .send_request      (send_request),
        .serial_data_out   (line[1]),
        .is_active         (active[1]),
        .tx_done           (done[1])
    );

    task automatic tick;
        @(posedge baud_clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] exp_line,
                             input logic exp_act, input logic exp_done);
        check({tag, " line_even"},   {7'd0, line[0]},   {7'd0, exp_line[0]});
        check({tag, " line_odd"},    {7'd0, line[1]},   {7'd0, exp_line[1]});
        check({tag, " active_even"}, {7'd0, active[0]}, {7'd0, exp_act});
        check({tag, " active_odd"},  {7'd0, active[1]}, {7'd0, exp_act});
        check({tag, " done_even"},   {7'd0, done[0]},   {7'd0, exp_done});
        check({tag, " done_odd"},    {7'd0, done[1]},   {7'd0, exp_done});
    endtask

    function automatic logic exp_parity(input logic [7:0] d, input logic odd);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += d[i];
        return logic'(ones % 2) ^ odd;
    endfunction

    // Bits in transmit order: bit 0 first. Unused top bit is idle-high.
    function automatic logic [10:0] expected_frame(input logic [7:0] d, input logic odd);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
`ifdef PARITY_BIT_EN
        f[9] = exp_parity(d, odd);
`else
        f[9] = odd | 1'b1;
`endif
        return f;
    endfunction

    // Accept a byte (DUT must be idle), then follow the whole frame.
    // after_data: value put on parallel_data_in right after acceptance.
    // poke_cycle: frame cycle at whose end a request with poke_data is pulsed.
    // reset_cycle: frame cycle in which reset is asserted (frame aborted).
    task automatic send_frame(input string tag, input logic [7:0] data, input bit keep_request,
                              input logic [7:0] after_data, input int poke_cycle,
                              input logic [7:0] poke_data, input int reset_cycle);
        logic [10:0] fe, fo, rxe, rxo;
        logic [1:0]  exp_line;
        int          idx;
        fe  = expected_frame(data, 1'b0);
        fo  = expected_frame(data, 1'b1);
        rxe = '1;
        rxo = '1;
        parallel_data_in = data;
        send_request     = 1'b1;
        tick();
        if (!keep_request) send_request = 1'b0;
        parallel_data_in = after_data;
        for (int k = 1; k <= FRAME_CYCLES; k++) begin
            if (k == reset_cycle) begin
                reset_active_high = 1'b1;
                tick();
                reset_active_high = 1'b0;
                check_all({tag, " reset_abort"}, 2'b11, 1'b0, 1'b0);
                return;
            end
            idx      = (k - 1) / CPB;
            exp_line = {fo[idx], fe[idx]};
            check_all($sformatf("%s c%0d", tag, k), exp_line, 1'b1, 1'b0);
            if ((k - 1) % CPB == 7) begin
                rxe[idx] = line[0];
                rxo[idx] = line[1];
            end
            if (k == poke_cycle) begin
                send_request     = 1'b1;
                parallel_data_in = poke_data;
            end
            tick();
            if (k == poke_cycle) begin
                send_request     = 1'b0;
                parallel_data_in = after_data;
            end
        end
        check_all({tag, " end"}, 2'b11, 1'b0, 1'b1);
        check({tag, " rx_start_even"}, {7'd0, rxe[0]}, 8'h00);
        check({tag, " rx_data_even"},  rxe[8:1], data);
        check({tag, " rx_data_odd"},   rxo[8:1], data);
        check({tag, " rx_stop_even"},  {7'd0, rxe[FRAME_BITS-1]}, 8'h01);
        check({tag, " rx_stop_odd"},   {7'd0, rxo[FRAME_BITS-1]}, 8'h01);
`ifdef PARITY_BIT_EN
        check({tag, " rx_par_even"}, {7'd0, rxe[9]}, {7'd0, exp_parity(data, 1'b0)});
        check({tag, " rx_par_odd"},  {7'd0, rxo[9]}, {7'd0, exp_parity(data, 1'b1)});
`endif
        $display("frame %s data=%02h rx_even=%02h rx_odd=%02h", tag, data, rxe[8:1], rxo[8:1]);
        if (!keep_request) begin
            tick();
            check_all({tag, " idle"}, 2'b11, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] d;
        // Reset, with a request held during it that must not be taken
        reset_active_high = 1'b1;
        send_request      = 1'b1;
        parallel_data_in  = 8'h12;
        repeat (3) tick();
        check_all("reset", 2'b11, 1'b0, 1'b0);
        reset_active_high = 1'b0;
        send_request      = 1'b0;
        tick();
        check_all("post_reset", 2'b11, 1'b0, 1'b0);

        send_frame("x55", 8'h55, 1'b0, 8'hAA, 0, 8'h00, 0);
        send_frame("x01", 8'h01, 1'b0, 8'h00, 0, 8'h00, 0);
        send_frame("x80", 8'h80, 1'b0, 8'h7F, 0, 8'h00, 0);
        send_frame("xA5", 8'hA5, 1'b0, 8'h5A, 0, 8'h00, 0);
        // Back-to-back: request held high, next byte presented after acceptance
        send_frame("b2b_3C", 8'h3C, 1'b1, 8'hC3, 0, 8'h00, 0);
        send_frame("b2b_C3", 8'hC3, 1'b0, 8'h00, 0, 8'h00, 0);
        // Request while busy must be ignored
        send_frame("busy_00", 8'h00, 1'b0, 8'h00, 40, 8'hFF, 0);
        // Reset during data bit 3 (frame cycles 65..80), then a clean frame
        send_frame("abort", 8'h96, 1'b0, 8'h00, 0, 8'h00, 70);
        tick();
        check_all("abort_idle", 2'b11, 1'b0, 1'b0);
        send_frame("after_abort", 8'h69, 1'b0, 8'h00, 0, 8'h00, 0);

        for (int n = 0; n < 256; n++) begin
            d = 8'($urandom);
            send_frame($sformatf("rnd%0d", n), d, 1'b0, 8'($urandom), 0, 8'h00, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
